fpto_int_arb: RTL and testbench

//  Shares one combinational fpto_int converter among NUM_REQ requesters (e.g. lane/issue ports).

---
 rtl/fpto_int_arb_if.sv | 32 +++
 rtl/fpto_int_arb.sv | 94 +++++++++
 tb/tb_fpto_int_arb.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fpto_int_arb_if.sv
// fpto_int_arb_if: requester, converter and response signals of the shared fpto_int arbiter.
interface fpto_int_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_vld;
  logic [NUM_REQ-1:0]    req_rdy;
  logic [4*NUM_REQ-1:0]  req_ctrl;
  logic [32*NUM_REQ-1:0] req_data;
  logic                  cvt_inst_vld;
  logic                  cvt_src_prec;
  logic                  cvt_dst_prec;
  logic                  cvt_src_pos;
  logic                  cvt_dst_pos;
  logic [31:0]           cvt_in_reg;
  logic [31:0]           cvt_out_reg;
  logic                  cvt_result_vld;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  modport slave (
    input  req_vld, req_ctrl, req_data, cvt_out_reg, cvt_result_vld, rsp_rdy,
    output req_rdy, cvt_inst_vld, cvt_src_prec, cvt_dst_prec, cvt_src_pos, cvt_dst_pos,
           cvt_in_reg, rsp_vld, rsp_id, rsp_data
  );
  modport master (
    output req_vld, req_ctrl, req_data, cvt_out_reg, cvt_result_vld, rsp_rdy,
    input  req_rdy, cvt_inst_vld, cvt_src_prec, cvt_dst_prec, cvt_src_pos, cvt_dst_pos,
           cvt_in_reg, rsp_vld, rsp_id, rsp_data
  );
endinterface

// File: rtl/fpto_int_arb.sv
// fpto_int_arb: round-robin share of one combinational fpto_int converter, issue reg (S1) + response reg (S2).
module fpto_int_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  fpto_int_arb_if.slave    bus,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] done_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2} state_e;
  state_e st;
  logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [3:0] s1_ctrl_q, s1_ctrl_d, sel_ctrl;
  logic [31:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d, sel_data;
  logic [ID_W-1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d, ptr_q, ptr_d, gid, idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic adv1, adv2, hit, accept, cap;
  assign adv2 = !s2_vld_q || bus.rsp_rdy;
  assign adv1 = !s1_vld_q || adv2;
  assign accept = adv1 && !flush && hit;
  assign cap = adv2 && s1_vld_q && bus.cvt_result_vld;
  // search begins one past the last accepted requester
  always_comb begin
    gid = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!hit && bus.req_vld[idx]) begin
        hit = 1'b1;
        gid = idx;
      end
    end
  end
  always_comb begin
    sel_ctrl = '0;
    sel_data = '0;
    bus.req_rdy = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gid == ID_W'(k)) begin
        sel_ctrl = bus.req_ctrl[4*k +: 4];
        sel_data = bus.req_data[32*k +: 32];
        bus.req_rdy[k] = accept;
      end
    end
  end
  always_comb begin
    s1_vld_d  = flush ? 1'b0 : adv1 ? accept : s1_vld_q;
    s1_ctrl_d = accept ? sel_ctrl : s1_ctrl_q;
    s1_data_d = accept ? sel_data : s1_data_q;
    s1_id_d   = accept ? gid : s1_id_q;
    s2_vld_d  = flush ? 1'b0 : adv2 ? cap : s2_vld_q;
    s2_data_d = cap ? bus.cvt_out_reg : s2_data_q;
    s2_id_d   = cap ? s1_id_q : s2_id_q;
    ptr_d     = accept ? gid : ptr_q;
    cnt_d     = cnt_q + CNT_W'(s2_vld_q && bus.rsp_rdy);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_ctrl_q <= '0;
      s1_data_q <= '0;
      s1_id_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_id_q   <= '0;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_ctrl_q <= s1_ctrl_d;
      s1_data_q <= s1_data_d;
      s1_id_q   <= s1_id_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_id_q   <= s2_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end
  assign st = (!s1_vld_q && !s2_vld_q) ? IDLE : (s2_vld_q && !bus.rsp_rdy) ? STALL : RUN;
  assign state = st;
  assign done_cnt = cnt_q;
  assign bus.cvt_inst_vld = s1_vld_q;
  assign {bus.cvt_src_prec, bus.cvt_dst_prec, bus.cvt_src_pos, bus.cvt_dst_pos} = s1_ctrl_q;
  assign bus.cvt_in_reg = s1_data_q;
  assign bus.rsp_vld = s2_vld_q;
  assign bus.rsp_id = s2_id_q;
  assign bus.rsp_data = s2_data_q;
endmodule

// File: tb/tb_fpto_int_arb.sv
// tb_fpto_int_arb: directed checks of fpto_int_arb with a behavioural fpto_int (truncating, saturating) on cvt_*.
module tb_fpto_int_arb;
  logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0, kill = 1'b0;
  logic [1:0] state;
  logic [15:0] done_cnt;
  int total = 0, bad = 0;
  logic [31:0] fp [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

  fpto_int_arb_if #(.NUM_REQ(4)) bus ();
  fpto_int_arb #(.NUM_REQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .state(state), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f16(input logic [15:0] x);
    int e;
    logic [15:0] m;
    e = int'(x[14:10]) - 15;
    if (e < 0) return 16'h0;
    if (e >= 15) return 16'h8000;
    m = {5'b0, 1'b1, x[9:0]};
    m = (e >= 10) ? m << (e - 10) : m >> (10 - e);
    return x[15] ? -m : m;
  endfunction

  function automatic logic [31:0] f32(input logic [31:0] x);
    int e;
    logic [31:0] m;
    e = int'(x[30:23]) - 127;
    if (e < 0) return 32'h0;
    if (e >= 31) return 32'h8000_0000;
    m = {8'b0, 1'b1, x[22:0]};
    m = (e >= 23) ? m << (e - 23) : m >> (23 - e);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] cvt(input logic sp, input logic [31:0] x);
    return sp ? f32(x) : {f16(x[31:16]), f16(x[15:0])};
  endfunction

  assign bus.cvt_out_reg = cvt(bus.cvt_src_prec, bus.cvt_in_reg);
  assign bus.cvt_result_vld = bus.cvt_inst_vld && !kill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] d);
    bus.req_ctrl[4*i +: 4] = c;
    bus.req_data[32*i +: 32] = d;
  endtask

  task automatic do_one(input int i, input logic [3:0] c, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
    set_req(i, c, d);
    bus.req_vld = 4'(1 << i);
    #1 chk({tag, "_rdy"}, 32'(bus.req_rdy), 32'(1 << i));
    tick();
    bus.req_vld = '0;
    chk({tag, "_s1"}, 32'(bus.rsp_vld), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(bus.rsp_vld), 32'd1);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(i));
    chk({tag, "_data"}, bus.rsp_data, exp);
    tick();
  endtask

  initial begin
    bus.req_vld = '0;
    bus.req_ctrl = '0;
    bus.req_data = '0;
    bus.rsp_rdy = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_inst_vld", 32'(bus.cvt_inst_vld), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(done_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    // single ops: fp16 scalar, packed fp16 pair, fp32, fp32 overflow
    do_one(0, 4'b0000, 32'h0000_3C00, 32'h0000_0001, "t1");
    chk("t1_cnt", 32'(done_cnt), 32'd1);
    chk("t1_idle", 32'(state), 32'd0);
    do_one(1, 4'b0000, 32'hC500_3C00, 32'hFFFB_0001, "t2_sub");
    do_one(2, 4'b1100, 32'h4020_0000, 32'h0000_0002, "t2_fp32");
    do_one(3, 4'b1100, 32'h5015_02F9, 32'h8000_0000, "t2_ovf");
    chk("t2_cnt", 32'(done_cnt), 32'd4);
    // round robin streaming
    for (int i = 0; i < 4; i++) set_req(i, 4'b1100, fp[i]);
    bus.req_vld = 4'hF;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) begin
        bus.req_vld = '0;
        #1;
      end
      if (k < 8) chk("rr_grant", 32'(bus.req_rdy), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk("rr_vld", 32'(bus.rsp_vld), 32'd1);
        chk("rr_id", 32'(bus.rsp_id), 32'((k - 2) % 4));
        chk("rr_data", bus.rsp_data, 32'((k - 2) % 4 + 1));
      end
      tick();
    end
    chk("rr_cnt", 32'(done_cnt), 32'd12);
    chk("rr_idle", 32'(state), 32'd0);
    // backpressure
    bus.rsp_rdy = 1'b0;
    bus.req_vld = 4'hF;
    #1 chk("bp_rdy0", 32'(bus.req_rdy), 32'h1);
    tick();
    chk("bp_rdy1", 32'(bus.req_rdy), 32'h2);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("bp_rdy_stall", 32'(bus.req_rdy), 32'h0);
      chk("bp_state", 32'(state), 32'd2);
      chk("bp_id", 32'(bus.rsp_id), 32'd0);
      chk("bp_data", bus.rsp_data, 32'd1);
      tick();
    end
    bus.rsp_rdy = 1'b1;
    bus.req_vld = '0;
    #1;
    chk("bp_run", 32'(state), 32'd1);
    chk("bp_rel_id0", 32'(bus.rsp_id), 32'd0);
    tick();
    chk("bp_rel_vld1", 32'(bus.rsp_vld), 32'd1);
    chk("bp_rel_id1", 32'(bus.rsp_id), 32'd1);
    chk("bp_rel_data1", bus.rsp_data, 32'd2);
    tick();
    chk("bp_drain", 32'(bus.rsp_vld), 32'd0);
    chk("bp_cnt", 32'(done_cnt), 32'd14);
    // flush with both stages full, response handshaked in the flush cycle
    bus.rsp_rdy = 1'b0;
    bus.req_vld = 4'hF;
    #1;
    tick();
    tick();
    chk("fl_full_vld", 32'(bus.rsp_vld), 32'd1);
    chk("fl_full_id", 32'(bus.rsp_id), 32'd2);
    chk("fl_full_state", 32'(state), 32'd2);
    flush = 1'b1;
    bus.rsp_rdy = 1'b1;
    #1 chk("fl_rdy", 32'(bus.req_rdy), 32'h0);
    tick();
    flush = 1'b0;
    bus.req_vld = '0;
    chk("fl_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("fl_state", 32'(state), 32'd0);
    chk("fl_inst_vld", 32'(bus.cvt_inst_vld), 32'd0);
    chk("fl_cnt", 32'(done_cnt), 32'd15);
    tick();
    chk("fl_no_ghost", 32'(bus.rsp_vld), 32'd0);
    bus.req_vld = 4'b1001;
    #1 chk("fl_resume", 32'(bus.req_rdy), 32'h1);
    tick();
    bus.req_vld = '0;
    tick();
    chk("fl_res_id", 32'(bus.rsp_id), 32'd0);
    chk("fl_res_data", bus.rsp_data, 32'd1);
    tick();
    chk("fl_res_cnt", 32'(done_cnt), 32'd16);
    // converter withholds result_vld: op is dropped
    bus.req_vld = 4'b0010;
    #1 chk("drop_rdy", 32'(bus.req_rdy), 32'h2);
    tick();
    bus.req_vld = '0;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("drop_vld", 32'(bus.rsp_vld), 32'd0);
    chk("drop_state", 32'(state), 32'd0);
    chk("drop_cnt", 32'(done_cnt), 32'd16);
    // asynchronous reset mid-stream
    bus.req_vld = 4'hF;
    #1;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("ar_inst_vld", 32'(bus.cvt_inst_vld), 32'd0);
    chk("ar_data", bus.rsp_data, 32'd0);
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_cnt", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ar_first", 32'(bus.req_rdy), 32'h1);
    tick();
    chk("ar_in_reg", bus.cvt_in_reg, 32'h3F80_0000);
    chk("ar_cnt2", 32'(done_cnt), 32'd0);
    bus.req_vld = '0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
